// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low 7-segment glyph constants (bits g..a) and the
// glyph classification shared by display encoders and checkers.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1011000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      HEX,
      DASH,
      BLANK,
      ILLEGAL
   } glyph_kind_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: inverse of the hex display encoder table.
// Maps an active-low g..a pattern to a nibble and its glyph class.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0]  pattern,
   output logic [3:0]  nibble,
   output glyph_kind_t kind
);

   always_comb begin
      nibble = 4'h0;
      kind   = HEX;
      unique case (pattern)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_DASH:  kind = DASH;
         SEG_BLANK: kind = BLANK;
         default:   kind = ILLEGAL;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit hex nibbles from a multiplexed
// active-low segment/digit-select bus, with frame strobes and error flag.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NDIG       = 8,
   parameter int STABLE_CYC = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [7:0]        nSEG,
   input  logic [NDIG-1:0]   nDIG,
   input  logic              CLR,
   output logic [4*NDIG-1:0] DOUT,
   output logic [NDIG-1:0]   DVALID,
   output logic [NDIG-1:0]   DP,
   output logic              FRAME,
   output logic              ERR
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYC);

   logic [7:0]        s_seg, p_seg;
   logic [NDIG-1:0]   s_dig, p_dig;
   logic [7:0]        cnt, cnt_nxt;
   logic [4*NDIG-1:0] dout, dout_nxt;
   logic [NDIG-1:0]   dvalid, dvalid_nxt;
   logic [NDIG-1:0]   dp, dp_nxt;
   logic [NDIG-1:0]   seen, seen_nxt, seen_all;
   logic [NDIG-1:0]   sel;
   logic              frame, frame_nxt;
   logic              err, err_nxt;
   logic [3:0]        n_low;
   logic              active, multi, changed, commit;
   logic [3:0]        nib;
   glyph_kind_t       kind;

   seg7_pattern_decode u_dec (
      .pattern (s_seg[6:0]),
      .nibble  (nib),
      .kind    (kind)
   );

   always_comb begin
      sel     = ~s_dig;
      n_low   = 4'($countones(sel));
      active  = (n_low == 4'd1);
      multi   = (n_low > 4'd1);
      changed = (s_seg != p_seg) || (s_dig != p_dig);

      cnt_nxt = cnt;
      if (!active)
         cnt_nxt = '0;
      else if (changed || (&p_dig))
         cnt_nxt = 8'd1;
      else if (cnt != STABLE)
         cnt_nxt = cnt + 8'd1;

      // Only the step into saturation commits; a held dwell stays quiet.
      commit = active && (cnt_nxt == STABLE) && (cnt != STABLE);
   end

   always_comb begin
      dout_nxt   = dout;
      dvalid_nxt = dvalid;
      dp_nxt     = dp;
      seen_nxt   = seen;
      seen_all   = seen | sel;
      frame_nxt  = 1'b0;
      err_nxt    = err | multi;

      if (commit) begin
         for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) begin
               dp_nxt[i] = ~s_seg[7];
               unique case (kind)
                  HEX: begin
                     dout_nxt[4*i +: 4] = nib;
                     dvalid_nxt[i]      = 1'b1;
                  end
                  DASH, BLANK: begin
                     dout_nxt[4*i +: 4] = 4'h0;
                     dvalid_nxt[i]      = 1'b0;
                  end
                  default: dvalid_nxt[i] = 1'b0;
               endcase
            end
         end
         if (kind == ILLEGAL)
            err_nxt = 1'b1;
         if (&seen_all) begin
            frame_nxt = 1'b1;
            seen_nxt  = '0;
         end else begin
            seen_nxt  = seen_all;
         end
      end
   end

   // Input/previous registers clear to an idle bus so a cleared
   // state reads as blanking rather than a select collision.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s_seg  <= '1;
         s_dig  <= '1;
         p_seg  <= '1;
         p_dig  <= '1;
         cnt    <= '0;
         dout   <= '0;
         dvalid <= '0;
         dp     <= '0;
         seen   <= '0;
         frame  <= 1'b0;
         err    <= 1'b0;
      end else if (CLR) begin
         s_seg  <= '1;
         s_dig  <= '1;
         p_seg  <= '1;
         p_dig  <= '1;
         cnt    <= '0;
         dout   <= '0;
         dvalid <= '0;
         dp     <= '0;
         seen   <= '0;
         frame  <= 1'b0;
         err    <= 1'b0;
      end else begin
         s_seg  <= nSEG;
         s_dig  <= nDIG;
         p_seg  <= s_seg;
         p_dig  <= s_dig;
         cnt    <= cnt_nxt;
         dout   <= dout_nxt;
         dvalid <= dvalid_nxt;
         dp     <= dp_nxt;
         seen   <= seen_nxt;
         frame  <= frame_nxt;
         err    <= err_nxt;
      end
   end

   assign DOUT   = dout;
   assign DVALID = dvalid;
   assign DP     = dp;
   assign FRAME  = frame;
   assign ERR    = err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans, short dwells, glyph
// classes, select collisions, CLR/RST timing and frame strobes.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CLR;
   logic [7:0]  nSEG;
   logic [7:0]  nDIG;
   logic [31:0] DOUT;
   logic [7:0]  DVALID;
   logic [7:0]  DP;
   logic        FRAME;
   logic        ERR;

   int n_cmp = 0;
   int n_bad = 0;
   int frame_cnt = 0;
   int f0;
   logic [6:0] glyph [16];
   logic [6:0] bad_pat;

   seg7_scan_decoder #(.NDIG(8), .STABLE_CYC(4)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .nSEG   (nSEG),
      .nDIG   (nDIG),
      .CLR    (CLR),
      .DOUT   (DOUT),
      .DVALID (DVALID),
      .DP     (DP),
      .FRAME  (FRAME),
      .ERR    (ERR)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK)
      if (FRAME === 1'b1) frame_cnt++;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic drive(input logic dp_on, input logic [6:0] pat,
                        input logic [7:0] dig);
      nSEG = {~dp_on, pat};
      nDIG = dig;
   endtask

   task automatic blank(input int n);
      nSEG = 8'hFF;
      nDIG = 8'hFF;
      step(n);
   endtask

   task automatic show(input int k, input logic dp_on,
                       input logic [6:0] pat);
      logic [7:0] d;
      d = ~(8'd1 << k);
      drive(dp_on, pat, d);
      step(6);
      blank(2);
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      glyph[0]  = SEG_0; glyph[1]  = SEG_1; glyph[2]  = SEG_2;
      glyph[3]  = SEG_3; glyph[4]  = SEG_4; glyph[5]  = SEG_5;
      glyph[6]  = SEG_6; glyph[7]  = SEG_7; glyph[8]  = SEG_8;
      glyph[9]  = SEG_9; glyph[10] = SEG_A; glyph[11] = SEG_B;
      glyph[12] = SEG_C; glyph[13] = SEG_D; glyph[14] = SEG_E;
      glyph[15] = SEG_F;
      bad_pat = 7'b1010101;

      RST = 1'b1;
      CLR = 1'b0;
      nSEG = 8'hFF;
      nDIG = 8'hFF;
      step(2);
      check("rst_dout", DOUT, 32'h0);
      check("rst_dvalid", {24'h0, DVALID}, 32'h0);
      check("rst_dp", {24'h0, DP}, 32'h0);
      check("rst_frame", {31'h0, FRAME}, 32'h0);
      check("rst_err", {31'h0, ERR}, 32'h0);
      RST = 1'b0;
      step(1);

      // Scan 1: digits 0..7, check commit latency and FRAME on digit 7
      f0 = frame_cnt;
      for (int k = 0; k < 7; k++) show(k, 1'b0, glyph[k]);
      drive(1'b0, SEG_7, 8'h7F);
      step(4);
      check("d7_not_yet", DOUT, 32'h06543210);
      check("frame_early", {31'h0, FRAME}, 32'h0);
      step(1);
      check("d7_commit", DOUT, 32'h76543210);
      check("frame_pulse", {31'h0, FRAME}, 32'h1);
      step(1);
      check("frame_one_cyc", {31'h0, FRAME}, 32'h0);
      blank(2);
      check("scan1_dvalid", {24'h0, DVALID}, 32'hFF);
      check("scan1_dp", {24'h0, DP}, 32'h0);
      check("scan1_err", {31'h0, ERR}, 32'h0);
      check("scan1_frames", frame_cnt - f0, 32'd1);

      // Short dwell of 3 samples must not commit; 4 commits at edge 5
      drive(1'b0, SEG_A, 8'hFB);
      step(3);
      blank(3);
      check("short_dwell", DOUT, 32'h76543210);
      drive(1'b0, SEG_A, 8'hFB);
      step(4);
      check("a_edge4", DOUT, 32'h76543210);
      step(1);
      check("a_edge5", DOUT, 32'h76543A10);
      blank(2);

      // Dash clears the digit; illegal glyph keeps it and sets ERR
      show(5, 1'b0, SEG_DASH);
      check("dash_dout", DOUT, 32'h76043A10);
      check("dash_dvalid", {24'h0, DVALID}, 32'hDF);
      check("dash_err", {31'h0, ERR}, 32'h0);
      show(5, 1'b0, bad_pat);
      check("ill5_dvalid", {24'h0, DVALID}, 32'hDF);
      check("ill5_err", {31'h0, ERR}, 32'h1);
      show(6, 1'b0, bad_pat);
      check("ill6_dout", DOUT, 32'h76043A10);
      check("ill6_dvalid", {24'h0, DVALID}, 32'h9F);

      // Scan 2: 8..F with DP on odd digits; ERR stays sticky
      f0 = frame_cnt;
      for (int k = 0; k < 8; k++) show(k, 1'(k % 2), glyph[8 + k]);
      check("scan2_dout", DOUT, 32'hFEDCBA98);
      check("scan2_dvalid", {24'h0, DVALID}, 32'hFF);
      check("scan2_dp", {24'h0, DP}, 32'hAA);
      check("scan2_err", {31'h0, ERR}, 32'h1);
      check("scan2_frames", frame_cnt - f0, 32'd1);

      CLR = 1'b1;
      step(1);
      CLR = 1'b0;
      check("clr_dout", DOUT, 32'h0);
      check("clr_dvalid", {24'h0, DVALID}, 32'h0);
      check("clr_dp", {24'h0, DP}, 32'h0);
      check("clr_err", {31'h0, ERR}, 32'h0);

      // Scan 3 then a select collision
      f0 = frame_cnt;
      for (int k = 0; k < 8; k++) show(k, 1'b0, glyph[k]);
      check("scan3_dout", DOUT, 32'h76543210);
      check("scan3_frames", frame_cnt - f0, 32'd1);
      check("scan3_err", {31'h0, ERR}, 32'h0);
      f0 = frame_cnt;
      drive(1'b0, SEG_1, 8'hF3);
      step(10);
      blank(2);
      check("multi_err", {31'h0, ERR}, 32'h1);
      check("multi_dout", DOUT, 32'h76543210);
      check("multi_dvalid", {24'h0, DVALID}, 32'hFF);
      check("multi_frames", frame_cnt - f0, 32'd0);
      CLR = 1'b1;
      step(1);
      CLR = 1'b0;
      check("clr2_err", {31'h0, ERR}, 32'h0);

      // CLR lands on the edge that would commit digit 7
      f0 = frame_cnt;
      for (int k = 0; k < 7; k++) show(k, 1'b0, glyph[k]);
      drive(1'b0, SEG_7, 8'h7F);
      step(4);
      CLR = 1'b1;
      step(1);
      CLR = 1'b0;
      nSEG = 8'hFF;
      nDIG = 8'hFF;
      check("clrc_frame", {31'h0, FRAME}, 32'h0);
      check("clrc_dout", DOUT, 32'h0);
      check("clrc_dvalid", {24'h0, DVALID}, 32'h0);
      blank(2);
      check("clrc_frames", frame_cnt - f0, 32'd0);

      // Seen must be empty: digit 7 first cannot close a frame early
      f0 = frame_cnt;
      show(7, 1'b0, SEG_7);
      for (int k = 0; k < 6; k++) show(k, 1'b0, glyph[k]);
      check("seen_clr_nofr", frame_cnt - f0, 32'd0);
      show(6, 1'b0, SEG_6);
      check("seen_clr_frame", frame_cnt - f0, 32'd1);
      check("scan4_dout", DOUT, 32'h76543210);

      // Asynchronous reset mid-dwell of digit 3 (F with DP)
      drive(1'b1, SEG_F, 8'hF7);
      step(2);
      RST = 1'b1;
      #1;
      check("arst_dout", DOUT, 32'h0);
      check("arst_dvalid", {24'h0, DVALID}, 32'h0);
      step(1);
      RST = 1'b0;
      step(4);
      check("rel_not_yet", DOUT, 32'h0);
      check("rel_dp_not_yet", {24'h0, DP}, 32'h0);
      step(1);
      check("rel_dout", DOUT, 32'h0000F000);
      check("rel_dp", {24'h0, DP}, 32'h08);
      check("rel_dvalid", {24'h0, DVALID}, 32'h08);
      blank(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
